// File: rtl/labs_pkg.sv
// rtl/labs_pkg.sv - shared widths and result-sink state encoding for the LABS datapath
package labs_pkg;

  // Default widths shared with calc_e_pl and the sequence generator.
  localparam int SEQ_WIDTH = 20;
  localparam int E_WIDTH   = 20;
  localparam int CNT_WIDTH = 32;

  // Result-sink control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sink_state_t;

endpackage

// File: rtl/labs_result_sink_sat_counter.sv
// rtl/labs_result_sink_sat_counter.sv - saturating up-counter with clear, load and enable
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  // Clear beats load beats increment; the count sticks once it reaches all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (en && !(&q)) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/labs_result_sink.sv
// rtl/labs_result_sink.sv - min-energy result sink for the calc_e_pl output stream
module labs_result_sink #(
  parameter int SEQ_WIDTH = labs_pkg::SEQ_WIDTH,
  parameter int E_WIDTH   = labs_pkg::E_WIDTH,
  parameter int CNT_WIDTH = labs_pkg::CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [CNT_WIDTH-1:0] i_total,
  input  logic                 i_pause,
  input  logic [SEQ_WIDTH-1:0] i_seq,
  input  logic [E_WIDTH-1:0]   i_e,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic [SEQ_WIDTH-1:0] o_best_seq,
  output logic [E_WIDTH-1:0]   o_best_e,
  output logic [CNT_WIDTH-1:0] o_best_cnt,
  output logic [CNT_WIDTH-1:0] o_count,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_new_best
);

  import labs_pkg::*;

  sink_state_t          state;
  sink_state_t          state_nxt;
  logic [CNT_WIDTH-1:0] total;
  logic                 accept;
  logic                 lower;
  logic                 tie;
  logic                 final_accept;

  // Ready depends only on registered state and the host pause, never on i_valid.
  assign o_ready = (state == RUN) && !i_pause;
  assign o_busy  = (state == RUN);
  assign o_done  = (state == DONE);

  // A start on the same edge wins, so the coincident result is dropped.
  assign accept       = i_valid && o_ready && !i_start;
  assign lower        = (i_e < o_best_e);
  assign tie          = (i_e == o_best_e);
  assign final_accept = accept && ((o_count + CNT_WIDTH'(1)) == total);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: run ends on the accept that reaches the total; start re-arms from anywhere.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = IDLE;
      RUN:     if (final_accept) state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (i_start) begin
      state_nxt = (i_total == '0) ? DONE : RUN;
    end
  end

  // Latch the expected result count at start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total <= '0;
    end else if (i_start) begin
      total <= i_total;
    end
  end

  // Track minimum energy and its first sequence; pulse new_best on a strictly lower energy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_best_e   <= '1;
      o_best_seq <= '0;
      o_new_best <= 1'b0;
    end else begin
      o_new_best <= 1'b0;
      if (i_start) begin
        o_best_e   <= '1;
        o_best_seq <= '0;
      end else if (accept) begin
        if (lower) begin
          o_best_e   <= i_e;
          o_best_seq <= i_seq;
          o_new_best <= 1'b1;
        end else if (tie && (o_best_cnt == '0)) begin
          // All-ones energy against the untouched initial minimum: first holder of the tie.
          o_best_seq <= i_seq;
        end
      end
    end
  end

  // Tie counter: reloads to one on a new minimum, saturating increment on equal energy.
  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_best_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (i_start),
    .load    (accept && lower),
    .load_val(CNT_WIDTH'(1)),
    .en      (accept && tie),
    .q       (o_best_cnt)
  );

  // Accepted-result counter; it never saturates because the run stops at total.
  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_count (
    .clk     (clk),
    .rst     (rst),
    .clr     (i_start),
    .load    (1'b0),
    .load_val('0),
    .en      (accept),
    .q       (o_count)
  );

endmodule

// File: tb/tb_labs_result_sink.sv
// tb/tb_labs_result_sink.sv - directed scoreboard bench for labs_result_sink
module tb_labs_result_sink;

  localparam int SW = 20;
  localparam int EW = 20;
  localparam int CW = 32;

  typedef struct packed {
    logic [EW-1:0] best_e;
    logic [SW-1:0] best_seq;
    logic [CW-1:0] best_cnt;
    logic [CW-1:0] count;
    logic          busy;
    logic          done;
    logic          nb;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          i_start;
  logic [CW-1:0] i_total;
  logic          i_pause;
  logic [SW-1:0] i_seq;
  logic [EW-1:0] i_e;
  logic          i_valid;
  logic          o_ready;
  logic [SW-1:0] o_best_seq;
  logic [EW-1:0] o_best_e;
  logic [CW-1:0] o_best_cnt;
  logic [CW-1:0] o_count;
  logic          o_busy;
  logic          o_done;
  logic          o_new_best;

  int n_checks = 0;
  int n_fails  = 0;
  int nb_pulses = 0;

  // Reference model state: 0 idle, 1 run, 2 done.
  int            m_state;
  logic [EW-1:0] m_best_e;
  logic [SW-1:0] m_best_seq;
  logic [CW-1:0] m_best_cnt;
  logic [CW-1:0] m_count;
  logic [CW-1:0] m_total;
  logic          m_nb;

  exp_t sb[$];

  labs_result_sink #(
    .SEQ_WIDTH(SW),
    .E_WIDTH  (EW),
    .CNT_WIDTH(CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_start   (i_start),
    .i_total   (i_total),
    .i_pause   (i_pause),
    .i_seq     (i_seq),
    .i_e       (i_e),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .o_best_seq(o_best_seq),
    .o_best_e  (o_best_e),
    .o_best_cnt(o_best_cnt),
    .o_count   (o_count),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_new_best(o_new_best)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state    = 0;
    m_best_e   = '1;
    m_best_seq = '0;
    m_best_cnt = '0;
    m_count    = '0;
    m_total    = '0;
    m_nb       = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"},    o_ready,    32'd0);
    check({tag, "_best_e"},   o_best_e,   32'h000FFFFF);
    check({tag, "_best_seq"}, o_best_seq, 32'd0);
    check({tag, "_best_cnt"}, o_best_cnt, 32'd0);
    check({tag, "_count"},    o_count,    32'd0);
    check({tag, "_busy"},     o_busy,     32'd0);
    check({tag, "_done"},     o_done,     32'd0);
    check({tag, "_new_best"}, o_new_best, 32'd0);
  endtask

  // One clock cycle: drive inputs, predict the edge, then compare the registered outputs.
  task automatic step(input string tag, input logic start, input logic [CW-1:0] total,
                      input logic valid, input logic [SW-1:0] seq, input logic [EW-1:0] e,
                      input logic pause);
    exp_t x;
    i_start = start;
    i_total = total;
    i_valid = valid;
    i_seq   = seq;
    i_e     = e;
    i_pause = pause;
    #1;
    check({tag, "_ready"}, o_ready, 32'((m_state == 1) && !pause));
    m_nb = 1'b0;
    if (start) begin
      m_best_e   = '1;
      m_best_seq = '0;
      m_best_cnt = '0;
      m_count    = '0;
      m_total    = total;
      m_state    = (total == 0) ? 2 : 1;
    end else if (valid && (m_state == 1) && !pause) begin
      if (e < m_best_e) begin
        m_best_e   = e;
        m_best_seq = seq;
        m_best_cnt = 1;
        m_nb       = 1'b1;
      end else if (e == m_best_e) begin
        if (m_best_cnt == 0) m_best_seq = seq;
        if (m_best_cnt != 32'hFFFF_FFFF) m_best_cnt = m_best_cnt + 1;
      end
      m_count = m_count + 1;
      if (m_count == m_total) m_state = 2;
    end
    x.best_e   = m_best_e;
    x.best_seq = m_best_seq;
    x.best_cnt = m_best_cnt;
    x.count    = m_count;
    x.busy     = (m_state == 1);
    x.done     = (m_state == 2);
    x.nb       = m_nb;
    sb.push_back(x);
    @(posedge clk);
    #1;
    i_start = 1'b0;
    x = sb.pop_front();
    if (o_new_best === 1'b1) nb_pulses++;
    check({tag, "_best_e"},   o_best_e,   x.best_e);
    check({tag, "_best_seq"}, o_best_seq, x.best_seq);
    check({tag, "_best_cnt"}, o_best_cnt, x.best_cnt);
    check({tag, "_count"},    o_count,    x.count);
    check({tag, "_busy"},     o_busy,     x.busy);
    check({tag, "_done"},     o_done,     x.done);
    check({tag, "_new_best"}, o_new_best, x.nb);
  endtask

  initial begin
    rst     = 1'b1;
    i_start = 1'b0;
    i_total = '0;
    i_pause = 1'b0;
    i_seq   = '0;
    i_e     = '0;
    i_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_reset_values("por");

    // Three results back to back, two new minima.
    nb_pulses = 0;
    step("s3_start", 1'b1, 32'd3, 1'b0, 20'h0, 20'd0, 1'b0);
    step("s3_r0", 1'b0, 32'd0, 1'b1, 20'h0BEEF, 20'd40, 1'b0);
    step("s3_r1", 1'b0, 32'd0, 1'b1, 20'hFFFFF, 20'd190, 1'b0);
    step("s3_r2", 1'b0, 32'd0, 1'b1, 20'h00055, 20'd12, 1'b0);
    check("s3_pulses", nb_pulses, 32'd2);
    check("s3_final_best_e", o_best_e, 32'd12);
    check("s3_final_done", o_done, 32'd1);
    step("s3_after_done", 1'b0, 32'd0, 1'b1, 20'h00077, 20'd1, 1'b0);
    step("s3_idle", 1'b0, 32'd0, 1'b0, 20'h0, 20'd0, 1'b0);

    // Ties at the minimum; first occurrence keeps the sequence.
    step("t4_start", 1'b1, 32'd4, 1'b0, 20'h0, 20'd0, 1'b0);
    step("t4_r0", 1'b0, 32'd0, 1'b1, 20'd1, 20'd8, 1'b0);
    step("t4_r1", 1'b0, 32'd0, 1'b1, 20'd2, 20'd8, 1'b0);
    step("t4_r2", 1'b0, 32'd0, 1'b1, 20'd3, 20'd5, 1'b0);
    step("t4_r3", 1'b0, 32'd0, 1'b1, 20'd4, 20'd5, 1'b0);
    check("t4_final_seq", o_best_seq, 32'd3);
    check("t4_final_cnt", o_best_cnt, 32'd2);

    // Valid held high across a three-cycle pause.
    step("p2_start", 1'b1, 32'd2, 1'b0, 20'h0, 20'd0, 1'b0);
    step("p2_r0", 1'b0, 32'd0, 1'b1, 20'h00010, 20'd30, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step("p2_pause", 1'b0, 32'd0, 1'b1, 20'h00011, 20'd20, 1'b1);
    end
    step("p2_r1", 1'b0, 32'd0, 1'b1, 20'h00011, 20'd20, 1'b0);
    step("p2_hold", 1'b0, 32'd0, 1'b1, 20'h00012, 20'd10, 1'b0);
    check("p2_final_count", o_count, 32'd2);

    // Start coinciding with a valid result drops that result.
    step("cs_start", 1'b1, 32'd5, 1'b0, 20'h0, 20'd0, 1'b0);
    step("cs_r0", 1'b0, 32'd0, 1'b1, 20'h00100, 20'd50, 1'b0);
    step("cs_restart", 1'b1, 32'd1, 1'b1, 20'h00101, 20'd3, 1'b0);
    check("cs_dropped_count", o_count, 32'd0);
    step("cs_r1", 1'b0, 32'd0, 1'b1, 20'h00102, 20'd60, 1'b0);
    check("cs_final_done", o_done, 32'd1);

    // All-ones energy against the initial minimum counts as the first tie.
    step("ff_start", 1'b1, 32'd2, 1'b0, 20'h0, 20'd0, 1'b0);
    step("ff_r0", 1'b0, 32'd0, 1'b1, 20'h00ABC, 20'hFFFFF, 1'b0);
    step("ff_r1", 1'b0, 32'd0, 1'b1, 20'h00DEF, 20'hFFFFF, 1'b0);
    check("ff_final_seq", o_best_seq, 32'h00ABC);

    // Zero total goes straight to done.
    step("z_start", 1'b1, 32'd0, 1'b0, 20'h0, 20'd0, 1'b0);
    step("z_idle", 1'b0, 32'd0, 1'b1, 20'h00001, 20'd1, 1'b0);

    // Asynchronous reset mid-run.
    step("ar_start", 1'b1, 32'd5, 1'b0, 20'h0, 20'd0, 1'b0);
    step("ar_r0", 1'b0, 32'd0, 1'b1, 20'h00200, 20'd7, 1'b0);
    step("ar_r1", 1'b0, 32'd0, 1'b1, 20'h00201, 20'd9, 1'b0);
    i_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_values("ar");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("ar_after", 1'b0, 32'd0, 1'b1, 20'h00202, 20'd2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
